// File: rtl/led_matrix_pkg.sv
// Shared types for the 8x8 LED matrix scanner: row index, row bitmap and frame.
package led_matrix_pkg;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned ROW_W = $clog2(ROWS);

  typedef logic [ROW_W-1:0]  row_idx_t;
  typedef logic [COLS-1:0]   row_bits_t;
  typedef row_bits_t [ROWS-1:0] frame_t;

  // Active-low one-hot row select for the given row index.
  function automatic row_bits_t row_select_n(input row_idx_t r);
    return ~(row_bits_t'(1) << r);
  endfunction

endpackage

// File: rtl/led_row_timer.sv
// Row multiplex timer: per-row dwell counter, row index, blanking window,
// frame boundary strobe and frame start strobe (all strobes combinational).
module led_row_timer
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_DWELL    = 3375,
  parameter int unsigned BLANK_CYCLES = 16,
  localparam int unsigned CNT_W       = $clog2(ROW_DWELL)
) (
  input  logic             clk,
  input  logic             rst_n,
  output row_idx_t         row_idx,
  output logic [CNT_W-1:0] cnt,
  output logic             blank_c,
  output logic             boundary_c,
  output logic             frame_start_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROW_DWELL - 1);
  localparam row_idx_t         ROW_LAST = row_idx_t'(ROWS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  row_idx_t         row_q, row_d;
  logic             row_last_c;

  assign row_last_c = (cnt_q == CNT_LAST);

  // Dwell counter rolls over into the next row; row index wraps 7 -> 0.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    row_d = row_q;
    if (row_last_c) begin
      cnt_d = '0;
      row_d = row_q + row_idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  assign row_idx       = row_q;
  assign cnt           = cnt_q;
  assign blank_c       = (32'(cnt_q) < BLANK_CYCLES);
  assign boundary_c    = row_last_c && (row_q == ROW_LAST);
  assign frame_start_c = (cnt_q == '0) && (row_q == '0);

endmodule

// File: rtl/led_matrix_scan.sv
// Double-buffered 8x8 LED matrix scanner with tear-free swap at frame boundaries.
// Optional BRIGHTNESS_PWM_EN adds per-row latched brightness PWM on the columns.
module led_matrix_scan
  import led_matrix_pkg::*;
#(
  parameter int unsigned ROW_DWELL    = 3375,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       swap_req,
  output logic       swap_done,
  output logic       frame_start,
  input  logic [3:0] brightness,
  output logic [7:0] LEDrow,
  output logic [7:0] LEDcol
);

  localparam int unsigned CNT_W = $clog2(ROW_DWELL);

  row_idx_t         row_idx;
  logic [CNT_W-1:0] cnt;
  logic             blank_c;
  logic             boundary_c;
  logic             frame_start_c;

  led_row_timer #(
    .ROW_DWELL    (ROW_DWELL),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .row_idx       (row_idx),
    .cnt           (cnt),
    .blank_c       (blank_c),
    .boundary_c    (boundary_c),
    .frame_start_c (frame_start_c)
  );

  frame_t    bank0_q, bank0_d;
  frame_t    bank1_q, bank1_d;
  logic      front_sel_q, front_sel_d;
  logic      swap_pending_q, swap_pending_d;
  logic      wr_ready_q, wr_ready_d;
  logic      swap_done_q, swap_done_d;
  logic      frame_start_q, frame_start_d;
  row_bits_t led_row_q, led_row_d;
  row_bits_t led_col_q, led_col_d;

  logic      wr_fire_c;
  logic      swap_fire_c;
  logic      duty_on_c;
  row_bits_t front_row_c;

  assign wr_fire_c   = wr_valid && wr_ready_q;
  assign swap_fire_c = boundary_c && swap_pending_q;
  assign front_row_c = front_sel_q ? bank1_q[row_idx] : bank0_q[row_idx];

`ifdef BRIGHTNESS_PWM_EN
  logic [3:0] bright_q, bright_d;

  // Brightness is sampled once per row so a change lands on the next row only.
  always_comb begin
    bright_d  = bright_q;
    if (cnt == '0) bright_d = brightness;
    duty_on_c = (4'(cnt) <= bright_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bright_q <= '0;
    else        bright_q <= bright_d;
  end
`else
  logic pwm_unused;
  assign pwm_unused = ^{brightness, cnt};
  assign duty_on_c  = 1'b1;
`endif

  // Writes only ever land in the back bank (the one not being displayed).
  always_comb begin
    bank0_d = bank0_q;
    bank1_d = bank1_q;
    if (wr_fire_c) begin
      if (front_sel_q) bank0_d[wr_row] = wr_data;
      else             bank1_d[wr_row] = wr_data;
    end
  end

  // Swap request is held until the next frame boundary; repeats are absorbed.
  always_comb begin
    swap_pending_d = swap_pending_q;
    front_sel_d    = front_sel_q;
    if (swap_fire_c) begin
      swap_pending_d = 1'b0;
      front_sel_d    = ~front_sel_q;
    end else if (swap_req) begin
      swap_pending_d = 1'b1;
    end
  end

  always_comb begin
    wr_ready_d    = ~swap_pending_d;
    swap_done_d   = swap_fire_c;
    frame_start_d = frame_start_c;
    led_row_d     = row_select_n(row_idx);
    led_col_d     = (blank_c || !duty_on_c) ? '0 : front_row_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_q        <= '0;
      bank1_q        <= '0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      wr_ready_q     <= 1'b0;
      swap_done_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      led_row_q      <= '1;
      led_col_q      <= '0;
    end else begin
      bank0_q        <= bank0_d;
      bank1_q        <= bank1_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      wr_ready_q     <= wr_ready_d;
      swap_done_q    <= swap_done_d;
      frame_start_q  <= frame_start_d;
      led_row_q      <= led_row_d;
      led_col_q      <= led_col_d;
    end
  end

  assign wr_ready    = wr_ready_q;
  assign swap_done   = swap_done_q;
  assign frame_start = frame_start_q;
  assign LEDrow      = led_row_q;
  assign LEDcol      = led_col_q;

endmodule
